// File: rtl/instruction_fetch_unit.sv
// Instruction fetch/decode front end: walks the prefetch queue one byte per
// ce_1 and assembles prefixes, opcode, ModRM, displacement and immediate into
// a single instruction record that is held until the EU acknowledges it.
module instruction_fetch_unit (
  input  logic            clk,
  input  logic            reset,
  input  logic            ce_1,
  input  logic            ce_2,
  input  logic [7:0][7:0] ipq,
  input  logic [3:0]      ipq_len,
  output logic [15:0]     ipq_head,
  output logic            pfp_set,
  input  logic            branch_req,
  input  logic [15:0]     branch_target,
  output logic [7:0]      lut_opcode,
  input  logic            lut_has_modrm,
  input  logic [1:0]      lut_imm_bytes,
  output logic            inst_valid,
  input  logic            inst_ack,
  output logic [15:0]     inst_pc,
  output logic [3:0]      inst_len,
  output logic [7:0]      inst_opcode,
  output logic [7:0]      inst_modrm,
  output logic [15:0]     inst_disp,
  output logic [15:0]     inst_imm,
  output logic [1:0]      inst_seg,
  output logic            inst_seg_valid,
  output logic [1:0]      inst_rep,
  output logic            inst_lock
);

  localparam int unsigned LEN_MAX = 15;

  typedef enum logic [2:0] {S_PREFIX, S_MODRM, S_DISP, S_IMM, S_HOLD} state_t;

  state_t      r_state,  w_state_nxt;
  logic [15:0] r_head,   w_head_nxt;
  logic        r_pfp,    w_pfp_nxt;
  logic        r_valid,  w_valid_nxt;
  logic [15:0] r_pc,     w_pc_nxt;
  logic [3:0]  r_len,    w_len_nxt;
  logic [7:0]  r_opcode, w_opcode_nxt;
  logic [7:0]  r_modrm,  w_modrm_nxt;
  logic [15:0] r_disp,   w_disp_nxt;
  logic [15:0] r_imm,    w_imm_nxt;
  logic [1:0]  r_seg,    w_seg_nxt;
  logic        r_seg_v,  w_seg_v_nxt;
  logic [1:0]  r_rep,    w_rep_nxt;
  logic        r_lock,   w_lock_nxt;
  logic [1:0]  r_disp_cnt, w_disp_cnt_nxt;
  logic [1:0]  r_imm_cnt,  w_imm_cnt_nxt;
  logic        r_idx,      w_idx_nxt;

  logic [7:0]  w_byte;
  logic        w_byte_avail;
  logic [1:0]  w_modrm_disp;
  logic        w_consume;
  logic        w_clear;
  logic        w_unused;

  // Phase-2 enable carries no function in this block.
  assign w_unused     = ce_2;

  assign w_byte       = ipq[r_head[2:0]];
  assign w_byte_avail = (ipq_len != 4'd0) && !r_pfp;
  assign lut_opcode   = w_byte;

  // Displacement size implied by the ModRM byte at the queue head.
  always_comb begin
    w_modrm_disp = 2'd0;
    case (w_byte[7:6])
      2'b01:   w_modrm_disp = 2'd1;
      2'b10:   w_modrm_disp = 2'd2;
      2'b00:   w_modrm_disp = (w_byte[2:0] == 3'b110) ? 2'd2 : 2'd0;
      default: w_modrm_disp = 2'd0;
    endcase
  end

  // Next-state and record update; branch outranks everything including ack.
  always_comb begin
    w_state_nxt    = r_state;
    w_head_nxt     = r_head;
    w_pfp_nxt      = r_pfp;
    w_pc_nxt       = r_pc;
    w_len_nxt      = r_len;
    w_opcode_nxt   = r_opcode;
    w_modrm_nxt    = r_modrm;
    w_disp_nxt     = r_disp;
    w_imm_nxt      = r_imm;
    w_seg_nxt      = r_seg;
    w_seg_v_nxt    = r_seg_v;
    w_rep_nxt      = r_rep;
    w_lock_nxt     = r_lock;
    w_disp_cnt_nxt = r_disp_cnt;
    w_imm_cnt_nxt  = r_imm_cnt;
    w_idx_nxt      = r_idx;
    w_consume      = 1'b0;
    w_clear        = 1'b0;

    if (ce_1) begin
      w_pfp_nxt = 1'b0;
      if (branch_req) begin
        w_head_nxt = branch_target;
        w_pfp_nxt  = 1'b1;
        w_clear    = 1'b1;
      end else begin
        case (r_state)
          S_PREFIX: if (w_byte_avail) begin
            w_consume = 1'b1;
            if (r_len == 4'd0) w_pc_nxt = r_head;
            case (w_byte)
              8'h26, 8'h2E, 8'h36, 8'h3E: begin
                w_seg_nxt   = w_byte[4:3];
                w_seg_v_nxt = 1'b1;
              end
              8'hF2, 8'hF3: w_rep_nxt  = {1'b1, w_byte[0]};
              8'hF0:        w_lock_nxt = 1'b1;
              default: begin
                w_opcode_nxt  = w_byte;
                w_imm_cnt_nxt = lut_imm_bytes;
                w_idx_nxt     = 1'b0;
                if (lut_has_modrm)              w_state_nxt = S_MODRM;
                else if (lut_imm_bytes != 2'd0) w_state_nxt = S_IMM;
                else                            w_state_nxt = S_HOLD;
              end
            endcase
          end
          S_MODRM: if (w_byte_avail) begin
            w_consume      = 1'b1;
            w_modrm_nxt    = w_byte;
            w_disp_cnt_nxt = w_modrm_disp;
            w_idx_nxt      = 1'b0;
            if (w_modrm_disp != 2'd0)  w_state_nxt = S_DISP;
            else if (r_imm_cnt != 2'd0) w_state_nxt = S_IMM;
            else                        w_state_nxt = S_HOLD;
          end
          S_DISP: if (w_byte_avail) begin
            w_consume = 1'b1;
            if (r_disp_cnt == 2'd1 || r_idx) begin
              w_disp_nxt  = (r_disp_cnt == 2'd1) ? {{8{w_byte[7]}}, w_byte}
                                                 : {w_byte, r_disp[7:0]};
              w_idx_nxt   = 1'b0;
              w_state_nxt = (r_imm_cnt != 2'd0) ? S_IMM : S_HOLD;
            end else begin
              w_disp_nxt = {8'h00, w_byte};
              w_idx_nxt  = 1'b1;
            end
          end
          S_IMM: if (w_byte_avail) begin
            w_consume = 1'b1;
            if (r_imm_cnt == 2'd1 || r_idx) begin
              w_imm_nxt   = (r_imm_cnt == 2'd1) ? {8'h00, w_byte}
                                                : {w_byte, r_imm[7:0]};
              w_idx_nxt   = 1'b0;
              w_state_nxt = S_HOLD;
            end else begin
              w_imm_nxt = {8'h00, w_byte};
              w_idx_nxt = 1'b1;
            end
          end
          S_HOLD: if (inst_ack) w_clear = 1'b1;
          default: w_state_nxt = S_PREFIX;
        endcase
      end
    end

    if (w_consume) begin
      w_head_nxt = r_head + 16'd1;
      w_len_nxt  = (r_len == 4'(LEN_MAX)) ? r_len : r_len + 4'd1;
    end

    if (w_clear) begin
      w_state_nxt    = S_PREFIX;
      w_pc_nxt       = 16'h0000;
      w_len_nxt      = 4'd0;
      w_opcode_nxt   = 8'h00;
      w_modrm_nxt    = 8'h00;
      w_disp_nxt     = 16'h0000;
      w_imm_nxt      = 16'h0000;
      w_seg_nxt      = 2'd0;
      w_seg_v_nxt    = 1'b0;
      w_rep_nxt      = 2'd0;
      w_lock_nxt     = 1'b0;
      w_disp_cnt_nxt = 2'd0;
      w_imm_cnt_nxt  = 2'd0;
      w_idx_nxt      = 1'b0;
    end

    w_valid_nxt = (w_state_nxt == S_HOLD);
  end

  // State and record registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_PREFIX;
      r_head     <= 16'h0000;
      r_pfp      <= 1'b0;
      r_valid    <= 1'b0;
      r_pc       <= 16'h0000;
      r_len      <= 4'd0;
      r_opcode   <= 8'h00;
      r_modrm    <= 8'h00;
      r_disp     <= 16'h0000;
      r_imm      <= 16'h0000;
      r_seg      <= 2'd0;
      r_seg_v    <= 1'b0;
      r_rep      <= 2'd0;
      r_lock     <= 1'b0;
      r_disp_cnt <= 2'd0;
      r_imm_cnt  <= 2'd0;
      r_idx      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_head     <= w_head_nxt;
      r_pfp      <= w_pfp_nxt;
      r_valid    <= w_valid_nxt;
      r_pc       <= w_pc_nxt;
      r_len      <= w_len_nxt;
      r_opcode   <= w_opcode_nxt;
      r_modrm    <= w_modrm_nxt;
      r_disp     <= w_disp_nxt;
      r_imm      <= w_imm_nxt;
      r_seg      <= w_seg_nxt;
      r_seg_v    <= w_seg_v_nxt;
      r_rep      <= w_rep_nxt;
      r_lock     <= w_lock_nxt;
      r_disp_cnt <= w_disp_cnt_nxt;
      r_imm_cnt  <= w_imm_cnt_nxt;
      r_idx      <= w_idx_nxt;
    end
  end

  assign ipq_head       = r_head;
  assign pfp_set        = r_pfp;
  assign inst_valid     = r_valid;
  assign inst_pc        = r_pc;
  assign inst_len       = r_len;
  assign inst_opcode    = r_opcode;
  assign inst_modrm     = r_modrm;
  assign inst_disp      = r_disp;
  assign inst_imm       = r_imm;
  assign inst_seg       = r_seg;
  assign inst_seg_valid = r_seg_v;
  assign inst_rep       = r_rep;
  assign inst_lock      = r_lock;

endmodule
